bitwise_logic_seq: RTL and testbench
====================================

// Module: bitwise_logic_seq
// PURPOSE
//   Parametrised, multi-cycle bitwise logic unit (AND/OR/XOR/NOR) for the ALU.
//   Processes a WIDTH-bit operand pair LANE bits per cycle.
//   Uses valid/ready handshakes on both sides, so it can sit behind the
//   execute-stage operand latch and trade area for latency.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be a multiple of LANE
//   LANE   8   bits processed per RUN cycle; N = WIDTH/LANE chunks (N >= 1)
// PORTS
//   clock      in   1      single clock; all state updates on rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   in_valid   in   1      operand pair and op are presented
//   in_ready   out  1      unit can accept; high only in IDLE
//   op         in   2      00 AND, 01 OR, 10 XOR, 11 NOR (latched at accept)
//   A          in   WIDTH  operand A (latched at accept)
//   B          in   WIDTH  operand B (latched at accept)
//   out_valid  out  1      result is complete and stable; high only in DONE
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  result register
//   busy       out  1      high in RUN or DONE
//   zero       out  1      present only with BITWISE_ZERO_FLAG_EN (see below)
// BEHAVIOUR
// - Reset (reset_n=0, async):
//   - state=IDLE; chunk counter, latched A/B/op and result all go to 0.
//   - in_ready=1, out_valid=0, busy=0, zero=0.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE: on in_valid&&in_ready, latch A, B, op; clear result to 0;
//     set cnt=0; go to RUN. Otherwise hold.
//   - RUN: each edge writes result[cnt*LANE +: LANE] = op(A,B) on that slice
//     and increments cnt. At cnt==N-1, write the last slice and go to DONE.
//     Inputs are ignored in RUN.
//   - DONE: out_valid=1. result is held bit-stable until out_ready=1; on
//     that edge go to IDLE. result keeps its value until the next accept.
// - Latency: accept edge E0; RUN edges E1..EN; out_valid=1 after EN.
//   - Back-to-back throughput with in_valid and out_ready held high is one
//     op per N+2 cycles.
// - No bypass: in DONE, in_ready=0 even when out_ready=1. A new op is
//   accepted only on the edge after the output handshake.
// - N==1 (LANE==WIDTH): a single RUN cycle; the FSM is otherwise identical.
// - Slices not yet written read 0 while in RUN. result is meaningful only
//   while out_valid=1.
// - A/B/op changes after accept have no effect on the in-flight op.
// - Reset mid-RUN or mid-DONE: the in-flight op is discarded and no out_valid
//   is produced. The unit is ready (in_ready=1) from the first edge after
//   release.
// CONFIGURATION
//   BITWISE_ZERO_FLAG_EN defined:
//   - adds output port zero.
//   - zero is registered, =1 iff the final result==0, and is valid with
//     out_valid; it is 0 in IDLE and RUN.
//   - computed once on the EN edge; no extra latency.
//   BITWISE_ZERO_FLAG_EN undefined: no zero port and no related logic.
// TESTING (WIDTH=32, LANE=8, N=4)
//   1. OR A=F0F00000 B=00000F0F -> out_valid after E4,
//      result=F0F00F0F, busy=1 for E1..E5.
//   2. NOR A=0 B=0 -> FFFFFFFF. AND A=FFFF0000 B=0F0F0F0F -> 0F0F0000.
//   3. XOR A=B=12345678 -> result=0; zero=1 with BITWISE_ZERO_FLAG_EN.
//      XOR A=1 B=0 -> zero=0.
//   4. Backpressure: hold out_ready=0 for 3 cycles in DONE -> result
//      constant, out_valid=1, in_ready=0. Raise out_ready -> IDLE next edge.
//   5. Back-to-back: in_valid=out_ready=1 with 3 ops -> accepts spaced
//      exactly 6 cycles apart, results in order.
//   6. Assert reset_n=0 after E2 -> out_valid=0 and result=0 immediately;
//      after release in_ready=1 and a new op completes correctly.

Source files
------------

// File: rtl/bitwise_logic_seq_if.sv
// Handshake and operand/result bundle for bitwise_logic_seq.
// Optional zero flag carried when BITWISE_ZERO_FLAG_EN is defined.
interface bitwise_logic_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;
`ifdef BITWISE_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, result, busy, zero
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, result, busy, zero
    );
`else
    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, result, busy
    );
`endif
endinterface

// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), LANE bits per RUN cycle.
// Optional feature macro: BITWISE_ZERO_FLAG_EN adds a registered zero flag.
module bitwise_logic_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANE  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    bitwise_logic_seq_if.slave bus
);
    localparam int unsigned N     = WIDTH / LANE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [WIDTH-1:0] result_c;
    logic [LANE-1:0]  a_sl_c, b_sl_c, r_sl_c;
    logic             accept_c;
    logic             last_c;

    assign accept_c = bus.in_valid && in_ready_q;
    assign last_c   = (cnt_q == CNT_LAST);

    // Current slice result merged into the result word
    always_comb begin
        a_sl_c   = a_q[32'(cnt_q) * LANE +: LANE];
        b_sl_c   = b_q[32'(cnt_q) * LANE +: LANE];
        r_sl_c   = '0;
        case (op_q)
            2'b00:   r_sl_c = a_sl_c & b_sl_c;
            2'b01:   r_sl_c = a_sl_c | b_sl_c;
            2'b10:   r_sl_c = a_sl_c ^ b_sl_c;
            default: r_sl_c = ~(a_sl_c | b_sl_c);
        endcase
        result_c = result_q;
        result_c[32'(cnt_q) * LANE +: LANE] = r_sl_c;
    end

    // Next-state and next handshake outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = S_RUN;
            S_RUN:   if (last_c) state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and registered handshake outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Operand latch, slice counter and result accumulation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        op_q     <= bus.op;
                        result_q <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_RUN: begin
                    result_q <= result_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef BITWISE_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag set from the completed word on the final RUN edge, cleared on hand-off
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
        end else if (state_q == S_RUN && last_c) begin
            zero_q <= (result_c == '0);
        end else if (state_q == S_DONE && bus.out_ready) begin
            zero_q <= 1'b0;
        end
    end

    assign bus.zero = zero_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Scoreboard bench for bitwise_logic_seq: directed cases plus randomized ops.
module tb_bitwise_logic_seq;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANE  = 8;
    localparam int unsigned N     = WIDTH / LANE;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        int unsigned      due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int unsigned or_mode = 1;
    logic        ov_prev = 1'b0;
    exp_t        sb[$];

    always #5 clock = ~clock;

    bitwise_logic_seq_if #(.WIDTH(WIDTH)) bus ();

    bitwise_logic_seq #(.WIDTH(WIDTH), .LANE(LANE)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Consumer: out_ready updated just after each rising edge
    always @(posedge clock) begin
        #2;
        case (or_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Present one op; push its expected response once acceptance is certain
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit hold,
                         output int unsigned acc);
        int unsigned waited = 0;
        logic [WIDTH-1:0] r;
        acc = 0;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.A  = a;
        bus.B  = b;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        r = ref_op(op, a, b);
        sb.push_back('{res: r, z: (r == '0), due: acc + N});
        @(posedge clock);
        #1;
        bus.in_valid = hold;
        bus.op = 2'($urandom);
        bus.A  = $urandom;
        bus.B  = $urandom;
    endtask

    task automatic drain();
        int unsigned w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clock);
            w++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Monitor: compares every presented result against the scoreboard head
    always @(negedge clock) begin
        if (reset_n) begin
            chk("busy_vs_in_ready", bus.busy, !bus.in_ready);
            if (bus.out_valid) begin
                chk("in_ready_in_done", bus.in_ready, 0);
                chk("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    if (!ov_prev) chk("latency", cyc, sb[0].due);
                    chk("result", bus.result, sb[0].res);
`ifdef BITWISE_ZERO_FLAG_EN
                    chk("zero", bus.zero, sb[0].z);
`endif
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end else begin
`ifdef BITWISE_ZERO_FLAG_EN
                chk("zero_idle_run", bus.zero, 0);
`endif
            end
        end
        ov_prev = bus.out_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned a0, a1, a2, a3, w;
        logic [WIDTH-1:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.op = 2'd0;
        bus.A  = '0;
        bus.B  = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
`ifdef BITWISE_ZERO_FLAG_EN
        chk("rst_zero", bus.zero, 0);
`endif
        reset_n = 1'b1;

        // directed functional cases
        issue(2'd1, 32'hF0F00000, 32'h00000F0F, 1'b0, a0); drain();
        issue(2'd3, 32'h00000000, 32'h00000000, 1'b0, a0); drain();
        issue(2'd0, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, a0); drain();
        issue(2'd2, 32'h12345678, 32'h12345678, 1'b0, a0); drain();
        issue(2'd2, 32'h00000001, 32'h00000000, 1'b0, a0); drain();

        // backpressure in DONE
        or_mode = 0;
        issue(2'd1, $urandom, $urandom, 1'b0, a0);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clock);
            w++;
        end
        chk("bp_reached_done", bus.out_valid, 1);
        repeat (3) begin
            @(negedge clock);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        or_mode = 1;
        @(negedge clock);
        @(negedge clock);
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        drain();

        // back-to-back throughput
        issue(2'd0, 32'hA5A5A5A5, 32'h0FF00FF0, 1'b1, a1);
        issue(2'd2, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, a2);
        issue(2'd3, 32'h00FF00FF, 32'h0000FFFF, 1'b0, a3);
        chk("b2b_spacing_1", a2 - a1, N + 2);
        chk("b2b_spacing_2", a3 - a2, N + 2);
        drain();

        // reset in the middle of RUN
        issue(2'd1, 32'h11111111, 32'h22222222, 1'b0, a0);
        w = 0;
        while (cyc != a0 + 2 && w < 20) begin
            @(negedge clock);
            w++;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_in_ready", bus.in_ready, 1);
        issue(2'd2, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, a0);
        drain();

        // randomized ops under random backpressure
        or_mode = 2;
        repeat (40) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            issue(2'($urandom), ra, rb, 1'($urandom_range(0, 1)), a0);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        drain();
        or_mode = 1;
        repeat (20) @(negedge clock);
        chk("final_idle", bus.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
